// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO on the Ibex data bus.
// Define UART_TX_IRQ_EN to add the IRQ_EN register at 0xC and the irq_o port.
module uart_tx_periph #(
   parameter int unsigned FifoDepth   = 16,
   parameter int unsigned ClkDivReset = 434
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
`ifdef UART_TX_IRQ_EN
   output logic        irq_o,
`endif
   output logic        tx_o
);

   localparam int unsigned PW = $clog2(FifoDepth);
   localparam int unsigned LW = PW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e        state;
   logic [7:0]    mem [FifoDepth];
   logic [PW-1:0] wptr, rptr;
   logic [LW-1:0] level;
   logic [15:0]   clkdiv, div_eff, cnt;
   logic [7:0]    shift;
   logic [2:0]    idx;
   logic          full, empty, push, pop, wr;
   logic          sel_tx, sel_div;
   logic [31:0]   status, rd_val;
   logic          unused;

   assign gnt_o   = req_i;
   assign wr      = req_i & we_i;
   assign sel_tx  = addr_i[3:2] == 2'd0;
   assign sel_div = addr_i[3:2] == 2'd2;
   // full comes from the registered level, so a same-cycle pop cannot admit a push
   assign full    = level == LW'(FifoDepth);
   assign empty   = level == '0;
   assign push    = wr & sel_tx & be_i[0] & ~full;
   assign pop     = (state == IDLE) & ~empty;
   assign div_eff = (clkdiv == 16'd0) ? 16'd1 : clkdiv;
   assign status  = {16'h0, 8'(level), 5'h0, empty, full, state != IDLE};
   assign unused  = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:16], be_i[3:2]};

`ifdef UART_TX_IRQ_EN
   logic irq_en, irq_en_d;

   assign irq_en_d = (wr & (addr_i[3:2] == 2'd3) & be_i[0]) ? wdata_i[0] : irq_en;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_en <= 1'b0;
         irq_o  <= 1'b0;
      end else begin
         irq_en <= irq_en_d;
         irq_o  <= irq_en_d & empty & (state == IDLE);
      end
   end
`endif

   always_comb begin
      rd_val = '0;
      unique case (addr_i[3:2])
         2'd1:    rd_val = status;
         2'd2:    rd_val = {16'h0, clkdiv};
`ifdef UART_TX_IRQ_EN
         2'd3:    rd_val = {31'h0, irq_en};
`endif
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         err_o    <= 1'b0;
         clkdiv   <= 16'(ClkDivReset);
      end else begin
         rvalid_o <= req_i;
         rdata_o  <= (req_i & ~we_i) ? rd_val : '0;
         err_o    <= wr & sel_tx & be_i[0] & full;
         if (wr & sel_div & be_i[0]) clkdiv[7:0]  <= wdata_i[7:0];
         if (wr & sel_div & be_i[1]) clkdiv[15:8] <= wdata_i[15:8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wptr] <= wdata_i[7:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         unique case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // cnt is reloaded from div_eff at every bit boundary, so CLKDIV never changes mid-bit
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         tx_o  <= 1'b1;
         cnt   <= '0;
         shift <= '0;
         idx   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               tx_o <= 1'b1;
               if (!empty) begin
                  shift <= mem[rptr];
                  cnt   <= div_eff;
                  tx_o  <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (cnt == 16'd1) begin
                  cnt   <= div_eff;
                  idx   <= '0;
                  tx_o  <= shift[0];
                  state <= DATA;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            DATA: begin
               if (cnt == 16'd1) begin
                  cnt <= div_eff;
                  if (idx == 3'd7) begin
                     tx_o  <= 1'b1;
                     state <= STOP;
                  end else begin
                     idx  <= idx + 3'd1;
                     tx_o <= shift[idx + 3'd1];
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            STOP: begin
               if (cnt == 16'd1) state <= IDLE;
               else cnt <= cnt - 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped 8N1 UART transmitter on the Ibex data bus (req/gnt/rvalid protocol), sitting beside the SRAM behind the top-level data-port address decode.
- Software writes bytes to a TX FIFO; a baud-rate FSM serialises them onto tx_o.
- Gives FPGA example programs a console output path in addition to the LEDs.

Parameters:
- FifoDepth, 16, TX FIFO entries; power of two, >=2.
- ClkDivReset, 434, reset value of CLKDIV (cycles per bit; 50 MHz / 115200).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  bus request (already address-decoded for this block)
- we_i  in  1  write enable
- be_i  in  4  byte enables
- addr_i  in  32  byte address; only addr_i[3:2] decoded
- wdata_i  in  32  write data
- gnt_o  out  1  grant
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- err_o  out  1  error, qualified by rvalid_o
- tx_o  out  1  serial output, idle high

Behaviour:
- Bus handshake:
  - gnt_o = req_i (combinational, no stall).
  - rvalid_o asserts exactly one cycle after every granted request, for one cycle.
  - rdata_o and err_o are registered and valid only while rvalid_o is high; otherwise rdata_o = 0 and err_o = 0.
- Register map (word offsets):
  - 0x0 TXDATA, W: push wdata_i[7:0] if be_i[0]. Reads return 0.
  - 0x4 STATUS, RO: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bits[15:8] FIFO level. Writes ignored, no error.
  - 0x8 CLKDIV, RW: bits[15:0]. A write takes effect when the next bit period starts, never mid-bit. Value 0 is treated as 1.
  - 0xC: see Optional Feature.
- Errors: a TXDATA write while full drops the byte, leaves the FIFO unchanged, and returns err_o=1 with the response. All other accesses return err_o=0.
- FIFO:
  - full is evaluated on the registered level before any same-cycle pop, so a push while full is rejected even if a pop happens that cycle.
  - Simultaneous push and pop on a non-full FIFO leaves the level unchanged.
  - Pointers wrap modulo FifoDepth.
  - Level width is clog2(FifoDepth)+1, zero-extended into STATUS.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx_o=1. If the FIFO is non-empty, pop into shift register, load bit counter with CLKDIV, go to START.
  - START: tx_o=0 for CLKDIV cycles, then DATA with bit index 0.
  - DATA: tx_o = shift[idx], LSB first, CLKDIV cycles per bit. After idx 7, go to STOP.
  - STOP: tx_o=1 for CLKDIV cycles, then IDLE. If the FIFO is non-empty at that point, the next frame's START begins on the following cycle (one idle cycle between frames).
- Latency: for a TXDATA write granted in cycle N with FSM idle, tx_o falls at the start of cycle N+2. A frame lasts 10×CLKDIV cycles.
- tx_o is driven from a register.
- Reset values: tx_o=1, rvalid_o=0, err_o=0, rdata_o=0, FIFO empty, FSM IDLE, CLKDIV=ClkDivReset.
- Asserting reset mid-frame returns tx_o high asynchronously and discards queued bytes.
- Writes with be_i=0 are accepted with no effect and err_o=0.

Optional Feature:
- Macro: UART_TX_IRQ_EN.
- Defined:
  - Adds port irq_o (out, 1): registered, = IRQ_EN & empty & (state==IDLE).
  - Offset 0xC is IRQ_EN: RW bit0, reset 0.
  - irq_o reset 0.
- Undefined: no irq_o port; 0xC reads 0, writes are ignored with err_o=0.

Test Plan:
- Reset, then read 0x4 -> rdata_o=0x0000_0004 (empty), tx_o=1, read 0x8 -> 434.
- Write 0x8 = 4, then TXDATA = 0xA5 -> tx_o low 4 cycles starting N+2, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. STATUS busy=1 during the frame, 0 after.
- With CLKDIV=1, write 17 bytes back-to-back -> the FIFO fills as the FSM drains. Stall the FSM with CLKDIV=1000 to force full: 17th write returns err_o=1, level stays 16, STATUS=0x1002 plus busy bit.
- Write CLKDIV=0 then TXDATA=0xFF -> every bit lasts 1 cycle, identical to CLKDIV=1.
- Assert rst_ni mid-DATA -> tx_o=1 immediately; after release, STATUS=0x0004 and no residual frame is sent.
- UART_TX_IRQ_EN: write 0xC=1, send 0x55 -> irq_o=0 during the frame, rises 1 cycle after STOP ends; writing 0xC=0 drops irq_o on the next cycle.
